// File: rtl/clk_period_meter.sv
// Measures the period and high time of an asynchronous clock-like input in clk_i cycles,
// with a saturating timeout when the input is stuck.
module clk_period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             meas_clk_i,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RISE,
        MEASURE
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   meas_d_q;
    logic                   meas_s;
    logic                   rise;
    logic                   fall;

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       hcap_q;
    logic                   seen_fall_q;
    logic                   done_q;
    logic                   timeout_q;
    logic [CNT_W-1:0]       period_q;
    logic [CNT_W-1:0]       high_q;
    logic [CNT_W-1:0]       cnt_d;

    // NOTE: the synchronizer chain is reset too, so no stale edge survives a reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q   <= '0;
            meas_d_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], meas_clk_i};
            meas_d_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign meas_s = sync_q[SYNC_STAGES-1];
    assign rise   = meas_s & ~meas_d_q;
    assign fall   = ~meas_s & meas_d_q;
    assign cnt_d  = cnt_q + 1'b1;

    // NOTE: all state below uses non-blocking assignments so every branch reads pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hcap_q      <= '0;
            seen_fall_q <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            period_q    <= '0;
            high_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i && !done_q) begin
                        cnt_q       <= '0;
                        hcap_q      <= '0;
                        seen_fall_q <= 1'b0;
                        timeout_q   <= 1'b0;
                        state_q     <= WAIT_RISE;
                    end
                end
                WAIT_RISE: begin
                    if (rise) begin
                        cnt_q   <= {{(CNT_W-1){1'b0}}, 1'b1};
                        state_q <= MEASURE;
                    end else if (cnt_q == CNT_MAX) begin
                        period_q  <= CNT_MAX;
                        high_q    <= hcap_q;
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_q <= cnt_q;
                        high_q   <= hcap_q;
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                    end else if (cnt_q == CNT_MAX) begin
                        period_q  <= CNT_MAX;
                        high_q    <= hcap_q;
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                    if (fall && !seen_fall_q) begin
                        hcap_q      <= cnt_q;
                        seen_fall_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // busy covers the done cycle as well, so a start coinciding with done_o is not taken.
    assign busy_o    = (state_q != IDLE) || done_q;
    assign done_o    = done_q;
    assign timeout_o = timeout_q;
    assign period_o  = period_q;
    assign high_o    = high_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: table vectors, randomized patterns against an
// arithmetic model, and hand-written timeout / handshake / reset sequences.
module tb_clk_period_meter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        meas = 1'b0;
    logic        start16 = 1'b0;
    logic        start8 = 1'b0;
    logic        busy16, done16, to16;
    logic [15:0] period16, high16;
    logic        busy8, done8, to8;
    logic [7:0]  period8, high8;

    int n_checks = 0;
    int n_pass   = 0;

    int gen_h = 1;
    int gen_l = 1;
    int gen_ph = 0;
    bit gen_on = 1'b0;

    always #5 clk = ~clk;

    clk_period_meter #(.CNT_W(16), .SYNC_STAGES(2)) dut16 (
        .clk_i(clk), .rst_ni(rst_n), .meas_clk_i(meas), .start_i(start16),
        .busy_o(busy16), .done_o(done16), .timeout_o(to16),
        .period_o(period16), .high_o(high16)
    );

    clk_period_meter #(.CNT_W(8), .SYNC_STAGES(2)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .meas_clk_i(meas), .start_i(start8),
        .busy_o(busy8), .done_o(done8), .timeout_o(to8),
        .period_o(period8), .high_o(high8)
    );

    // Periodic clk-synchronous pattern: gen_l cycles low, then gen_h cycles high.
    always @(negedge clk) begin
        if (gen_on) begin
            meas = (gen_ph >= gen_l);
            gen_ph = (gen_ph + 1 == gen_h + gen_l) ? 0 : gen_ph + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic set_pattern(input int h, input int l);
        gen_h  = h;
        gen_l  = l;
        gen_ph = 0;
        gen_on = 1'b1;
        repeat (2 * (h + l) + 8) @(negedge clk);
    endtask

    // Reference: one full period of an H-high/L-low input, saturating at the counter limit.
    function automatic void model(input int h, input int l, input int max_cnt,
                                  output int p, output int hi, output int to);
        if (h + l > max_cnt) begin
            p  = max_cnt;
            hi = (h < max_cnt) ? h : 0;
            to = 1;
        end else begin
            p  = h + l;
            hi = h;
            to = 0;
        end
    endfunction

    task automatic run16(input string name, input int h, input int l);
        int p, hi, to, waited, extra;
        model(h, l, 65535, p, hi, to);
        @(negedge clk);
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        waited = 0;
        while (!done16 && waited < 4 * (h + l) + 200) begin
            @(negedge clk);
            waited++;
        end
        check({name, " done"}, done16, 1);
        check({name, " period"}, period16, p);
        check({name, " high"}, high16, hi);
        check({name, " timeout"}, to16, to);
        extra = 0;
        repeat (2 * (h + l) + 10) begin
            @(negedge clk);
            if (done16) extra++;
        end
        check({name, " extra done"}, extra, 0);
        check({name, " busy low"}, busy16, 0);
    endtask

    typedef struct {
        int h;
        int l;
        int exp_p;
        int exp_h;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int cyc, n_done, h, l, exp_p, exp_h, exp_to;

        vecs[0] = '{h: 3,   l: 5,   exp_p: 8,    exp_h: 3};
        vecs[1] = '{h: 1,   l: 1,   exp_p: 2,    exp_h: 1};
        vecs[2] = '{h: 500, l: 500, exp_p: 1000, exp_h: 500};
        vecs[3] = '{h: 1,   l: 7,   exp_p: 8,    exp_h: 1};
        vecs[4] = '{h: 7,   l: 1,   exp_p: 8,    exp_h: 7};

        repeat (3) @(negedge clk);
        check("reset busy", busy16, 0);
        check("reset done", done16, 0);
        check("reset timeout", to16, 0);
        check("reset period", period16, 0);
        check("reset high", high16, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            int p, hi;
            set_pattern(vecs[i].h, vecs[i].l);
            run16($sformatf("vec%0d", i), vecs[i].h, vecs[i].l);
            check($sformatf("vec%0d period vs table", i), period16, vecs[i].exp_p);
            check($sformatf("vec%0d high vs table", i), high16, vecs[i].exp_h);
        end

        for (int i = 0; i < 8; i++) begin
            h = $urandom_range(1, 40);
            l = $urandom_range(1, 40);
            set_pattern(h, l);
            repeat ($urandom_range(0, 7)) @(negedge clk);
            run16($sformatf("rand%0d h%0d l%0d", i, h, l), h, l);
        end

        // Stuck-low input on the 8-bit instance: done exactly 256 cycles after the start edge.
        gen_on = 1'b0;
        meas = 1'b0;
        repeat (10) @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        cyc = 0;
        while (!done8 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("stuck0 done latency", cyc, 256);
        check("stuck0 period", period8, 8'hFF);
        check("stuck0 high", high8, 0);
        check("stuck0 timeout", to8, 1);
        @(negedge clk);
        check("stuck0 done one cycle", done8, 0);

        // High for 10 cycles, then stuck low.
        repeat (5) @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        meas = 1'b1;
        repeat (10) @(negedge clk);
        meas = 1'b0;
        model(10, 1000, 255, exp_p, exp_h, exp_to);
        cyc = 0;
        while (!done8 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("stuck_after_high done", done8, 1);
        check("stuck_after_high period", period8, exp_p);
        check("stuck_after_high high", high8, exp_h);
        check("stuck_after_high timeout", to8, exp_to);

        // Extra starts while busy and in the done cycle must be ignored.
        set_pattern(3, 5);
        n_done = 0;
        for (int i = 0; i < 80; i++) begin
            start16 = (i == 0 || i == 3 || i == 6 || i == 9);
            if (done16) begin
                n_done++;
                start16 = 1'b1;
            end
            @(negedge clk);
        end
        start16 = 1'b0;
        check("ignore starts done count", n_done, 1);
        check("ignore starts period", period16, 8);
        check("ignore starts high", high16, 3);
        check("ignore starts busy", busy16, 0);

        // Reset in the middle of a measurement.
        @(negedge clk);
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        repeat (10) @(negedge clk);
        check("pre-reset busy", busy16, 1);
        rst_n = 1'b0;
        #1;
        check("mid reset busy", busy16, 0);
        check("mid reset done", done16, 0);
        check("mid reset period", period16, 0);
        check("mid reset high", high16, 0);
        check("mid reset timeout8", to8, 0);
        check("mid reset period8", period8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        repeat (30) begin
            @(negedge clk);
            if (done16) n_done++;
        end
        check("no done after reset", n_done, 0);
        run16("post-reset", 3, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
